// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types and helper functions for the IIR stream engine
package iir_pkg;

    // Engine sequencing states
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Widest accumulator the rounding helper accepts
    localparam int MAX_ACC_W = 64;

    // Accumulator width: full product width plus enough guard bits for
    // 2*order+1 signed terms, so the sum can never wrap.
    function automatic int acc_width(input int dw, input int cw, input int order);
        return dw + cw + $clog2(2 * order + 1) + 1;
    endfunction

    // Width of the MAC step index (counts 0 .. 2*order)
    function automatic int step_width(input int order);
        return $clog2(2 * order + 1);
    endfunction

    // Rounded/saturated result; value is two's complement, only the low
    // dw bits are meaningful after saturation.
    typedef struct packed {
        logic [MAX_ACC_W-1:0] value;
        logic                 clipped;
    } sat_t;

    // Round half-up by adding 2^(frac-1), arithmetic shift right by frac,
    // then clamp to the signed dw-bit range.
    function automatic sat_t round_sat(input logic signed [MAX_ACC_W-1:0] acc,
                                       input int frac, input int dw);
        logic signed [MAX_ACC_W-1:0] r;
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        sat_t o;
        if (frac > 0) begin
            r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        end else begin
            r = acc;
        end
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        o.value   = r;
        o.clipped = 1'b0;
        if (r > hi) begin
            o.value   = hi;
            o.clipped = 1'b1;
        end else if (r < lo) begin
            o.value   = lo;
            o.clipped = 1'b1;
        end
        return o;
    endfunction

endpackage

// File: rtl/iir_hist_bank.sv
// rtl/iir_hist_bank.sv - per-channel x/y delay-line storage for the IIR engine
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all history)
//   ch              channel selected for both read and shift
//   shift           shift strobe: x1<=x_in, y1<=y_in, older taps move down
//   x_in, y_in      newest input / output sample of channel ch
//   x_rd, y_rd      x1..xORDER / y1..yORDER of channel ch, tap 1 in the LSBs
module iir_hist_bank #(
    parameter int DW    = 16,
    parameter int ORDER = 2,
    parameter int NCH   = 1,
    parameter int CHW   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHW-1:0]      ch,
    input  logic                shift,
    input  logic [DW-1:0]       x_in,
    input  logic [DW-1:0]       y_in,
    output logic [ORDER*DW-1:0] x_rd,
    output logic [ORDER*DW-1:0] y_rd
);

    // Index [channel][tap-1]
    logic [DW-1:0] xs [NCH][ORDER];
    logic [DW-1:0] ys [NCH][ORDER];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    xs[c][k] <= '0;
                    ys[c][k] <= '0;
                end
            end
        end else if (shift) begin
            xs[ch][0] <= x_in;
            ys[ch][0] <= y_in;
            for (int k = 1; k < ORDER; k++) begin
                xs[ch][k] <= xs[ch][k-1];
                ys[ch][k] <= ys[ch][k-1];
            end
        end
    end

    always_comb begin
        x_rd = '0;
        y_rd = '0;
        for (int k = 0; k < ORDER; k++) begin
            x_rd[k*DW +: DW] = xs[ch][k];
            y_rd[k*DW +: DW] = ys[ch][k];
        end
    end

endmodule

// File: rtl/iir_stream_engine.sv
// rtl/iir_stream_engine.sv - direct-form-I IIR engine streaming ROM samples to RAM
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   b_coef          b0..bORDER (b0 in LSBs), static while running
//   a_coef          a1..aORDER (a1 in LSBs), static while running
//   DIn, data_done  sample at RAddr and its last-sample qualifier
//   load, RAddr     read request and address (= sample index n)
//   WEN, WAddr, Yn  write strobe, address (= n) and filtered sample
//   Finish          all samples written, held until reset
//   sat_flag        sticky: some output was clipped
module iir_stream_engine
    import iir_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int FRAC  = 14,
    parameter int ORDER = 2,
    parameter int NCH   = 1,
    parameter int AW    = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(ORDER+1)*CW-1:0] b_coef,
    input  logic [ORDER*CW-1:0]     a_coef,
    input  logic [DW-1:0]           DIn,
    input  logic                    data_done,
    output logic                    load,
    output logic [AW-1:0]           RAddr,
    output logic                    WEN,
    output logic [DW-1:0]           Yn,
    output logic [AW-1:0]           WAddr,
    output logic                    Finish,
    output logic                    sat_flag
);

    localparam int ACCW = acc_width(DW, CW, ORDER);
    localparam int SW   = step_width(ORDER);
    localparam int PW   = DW + CW;
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [SW-1:0]  LAST_STEP = SW'(2 * ORDER);
    localparam logic [CHW-1:0] LAST_CH   = CHW'(NCH - 1);

    state_t                  state;
    logic [SW-1:0]           step;
    logic [CHW-1:0]          ch;      // n mod NCH, tracked incrementally
    logic [AW-1:0]           n;
    logic [DW-1:0]           x0;
    logic                    last;
    logic signed [ACCW-1:0]  acc;

    logic [ORDER*DW-1:0]     x_hist;
    logic [ORDER*DW-1:0]     y_hist;

    logic [CW-1:0]           coef_sel;
    logic [DW-1:0]           data_sel;
    logic                    sub;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  prod_ext;
    logic signed [ACCW-1:0]  acc_next;
    logic signed [63:0]      acc64;
    sat_t                    res;

    iir_hist_bank #(
        .DW    (DW),
        .ORDER (ORDER),
        .NCH   (NCH),
        .CHW   (CHW)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .ch    (ch),
        .shift (state == WRITE),
        .x_in  (x0),
        .y_in  (Yn),
        .x_rd  (x_hist),
        .y_rd  (y_hist)
    );

    // Tap selection: step 0 -> b0*x0, 1..ORDER -> bk*xk,
    // ORDER+1..2*ORDER -> ak*yk (subtracted).
    always_comb begin
        coef_sel = b_coef[CW-1:0];
        data_sel = x0;
        sub      = 1'b0;
        for (int k = 1; k <= ORDER; k++) begin
            if (step == SW'(k)) begin
                coef_sel = b_coef[k*CW +: CW];
                data_sel = x_hist[(k-1)*DW +: DW];
            end
            if (step == SW'(ORDER + k)) begin
                coef_sel = a_coef[(k-1)*CW +: CW];
                data_sel = y_hist[(k-1)*DW +: DW];
                sub      = 1'b1;
            end
        end
    end

    // Single shared multiplier; operands sign-extended to the full product
    // width so the low PW bits form the exact signed product.
    always_comb begin
        prod     = {{DW{coef_sel[CW-1]}}, coef_sel} * {{CW{data_sel[DW-1]}}, data_sel};
        prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
        if (step == '0) begin
            acc_next = prod_ext;
        end else if (sub) begin
            acc_next = acc - prod_ext;
        end else begin
            acc_next = acc + prod_ext;
        end
        acc64 = {{(MAX_ACC_W-ACCW){acc_next[ACCW-1]}}, acc_next};
        res   = round_sat(acc64, FRAC, DW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            ch       <= '0;
            n        <= '0;
            x0       <= '0;
            last     <= 1'b0;
            acc      <= '0;
            load     <= 1'b0;
            RAddr    <= '0;
            WEN      <= 1'b0;
            Yn       <= '0;
            WAddr    <= '0;
            Finish   <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    load  <= 1'b1;
                    RAddr <= n;
                end
                FETCH: begin
                    x0    <= DIn;
                    // The top address is forced to be the last: no wrap.
                    last  <= data_done | (n == '1);
                    load  <= 1'b0;
                    step  <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc_next;
                    if (step == LAST_STEP) begin
                        // Result is formed from the final sum so Yn is
                        // already registered while WEN is high.
                        state <= WRITE;
                        WEN   <= 1'b1;
                        Yn    <= res.value[DW-1:0];
                        WAddr <= n;
                        if (res.clipped) begin
                            sat_flag <= 1'b1;
                        end
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                WRITE: begin
                    WEN <= 1'b0;
                    if (last) begin
                        state  <= DONE;
                        Finish <= 1'b1;
                    end else begin
                        n     <= n + 1'b1;
                        ch    <= (ch == LAST_CH) ? '0 : ch + 1'b1;
                        RAddr <= n + 1'b1;
                        load  <= 1'b1;
                        state <= FETCH;
                    end
                end
                DONE: begin
                    Finish <= 1'b1;
                    load   <= 1'b0;
                    WEN    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_stream_engine.sv
// tb/tb_iir_stream_engine.sv - self-checking bench for iir_stream_engine
module tb_iir_stream_engine;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int AW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic            rst;
    logic [3*CW-1:0] b_coef;
    logic [2*CW-1:0] a_coef;
    logic [DW-1:0]   DIn;
    logic            data_done;
    logic            load, WEN, Finish, sat_flag;
    logic [AW-1:0]   RAddr, WAddr;
    logic [DW-1:0]   Yn;

    // Two-channel instance
    logic            rst2;
    logic [3*CW-1:0] b_coef2;
    logic [2*CW-1:0] a_coef2;
    logic [DW-1:0]   DIn2;
    logic            data_done2;
    logic            load2, WEN2, Finish2, sat_flag2;
    logic [AW-1:0]   RAddr2, WAddr2;
    logic [DW-1:0]   Yn2;

    iir_stream_engine dut (
        .clk(clk), .rst(rst), .b_coef(b_coef), .a_coef(a_coef),
        .DIn(DIn), .data_done(data_done), .load(load), .RAddr(RAddr),
        .WEN(WEN), .Yn(Yn), .WAddr(WAddr), .Finish(Finish), .sat_flag(sat_flag)
    );

    iir_stream_engine #(.NCH(2)) dut2 (
        .clk(clk), .rst(rst2), .b_coef(b_coef2), .a_coef(a_coef2),
        .DIn(DIn2), .data_done(data_done2), .load(load2), .RAddr(RAddr2),
        .WEN(WEN2), .Yn(Yn2), .WAddr(WAddr2), .Finish(Finish2), .sat_flag(sat_flag2)
    );

    int vec  = 0;
    int miss = 0;

    int rom [64];
    int rom_len;
    int wr_addr[$], wr_data[$], wr_cyc[$], ld_cyc[$], ld_addr[$];
    int fin_cyc, cyc;
    int cb[3], ca[2];

    typedef struct {
        string name;
        int    b0, b1, b2, a1, a2;
        int    n;
        int    x[4];
        int    y[4];
        int    sat;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input longint act, input longint exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_coefs(input int b0, input int b1, input int b2, input int a1, input int a2);
        cb[0] = b0; cb[1] = b1; cb[2] = b2; ca[0] = a1; ca[1] = a2;
        b_coef = {16'(b2), 16'(b1), 16'(b0)};
        a_coef = {16'(a2), 16'(a1)};
    endtask

    // Difference equation per channel: same-channel history is k*nch samples back.
    task automatic model(input int nsamp, input int nch, output int y[$], output int clipped);
        longint acc, r;
        y.delete();
        clipped = 0;
        for (int i = 0; i < nsamp; i++) begin
            acc = longint'(cb[0]) * rom[i];
            for (int k = 1; k <= 2; k++) begin
                if (i - k * nch >= 0) begin
                    acc = acc + longint'(cb[k]) * rom[i - k * nch];
                    acc = acc - longint'(ca[k-1]) * y[i - k * nch];
                end
            end
            r = (acc + 8192) >>> 14;
            if (r > 32767) begin r = 32767; clipped = 1; end
            if (r < -32768) begin r = -32768; clipped = 1; end
            y.push_back(int'(r));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        DIn = '0;
        data_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic observe();
        if (load && WEN) begin
            vec++; miss++;
            $display("FAIL load_wen_exclusive: both high at cycle %0d", cyc);
        end
        if (load) begin
            ld_cyc.push_back(cyc);
            ld_addr.push_back(int'(RAddr));
            DIn = 16'(rom[RAddr[5:0]]);
            data_done = (int'(RAddr) == rom_len - 1);
        end else begin
            // Values outside a load cycle must be ignored by the DUT
            DIn = 16'($urandom);
            data_done = 1'($urandom);
        end
        if (WEN) begin
            wr_addr.push_back(int'(WAddr));
            wr_data.push_back(int'($signed(Yn)));
            wr_cyc.push_back(cyc);
        end
        if (Finish && fin_cyc < 0) fin_cyc = cyc;
    endtask

    task automatic run1(input int budget);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        ld_cyc.delete(); ld_addr.delete();
        fin_cyc = -1;
        cyc = 0;
        while (fin_cyc < 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            observe();
        end
        if (fin_cyc < 0) chk("finish_timeout", 0, 1);
        repeat (15) begin
            @(negedge clk);
            cyc++;
            observe();
        end
    endtask

    task automatic check_writes(input string tag, input int exp_y[$]);
        chk({tag, "_write_count"}, wr_data.size(), exp_y.size());
        for (int i = 0; i < exp_y.size() && i < wr_data.size(); i++) begin
            chk($sformatf("%s_waddr[%0d]", tag, i), wr_addr[i], i);
            chk($sformatf("%s_yn[%0d]", tag, i), wr_data[i], exp_y[i]);
        end
    endtask

    int exp_y[$];
    int clip;
    int found;
    int w2_addr[$], w2_data[$];
    int rom2[4];

    initial begin
        rst = 1'b1; DIn = '0; data_done = 1'b0;
        rst2 = 1'b1; DIn2 = '0; data_done2 = 1'b0;
        set_coefs(16384, 0, 0, 0, 0);
        b_coef2 = {16'd0, 16'd16384, 16'd16384};
        a_coef2 = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_load", load, 0);
        chk("rst_raddr", RAddr, 0);
        chk("rst_wen", WEN, 0);
        chk("rst_yn", Yn, 0);
        chk("rst_waddr", WAddr, 0);
        chk("rst_finish", Finish, 0);
        chk("rst_sat", sat_flag, 0);

        // Directed table
        tbl[0] = '{"impulse", 16384, 0, 0, -8192, 0, 4,
                   '{16384, 0, 0, 0}, '{16384, 8192, 4096, 2048}, 0};
        tbl[1] = '{"saturate", 32767, 0, 0, 0, 0, 2,
                   '{30000, -30000, 0, 0}, '{32767, -32768, 0, 0}, 1};
        tbl[2] = '{"average", 8192, 8192, 0, 0, 0, 4,
                   '{100, 200, -50, 7}, '{50, 150, 75, -21}, 0};
        tbl[3] = '{"rounding", 1, 0, 0, 0, 0, 4,
                   '{8192, 8191, -8192, -8193}, '{1, 0, 0, -1}, 0};

        for (int t = 0; t < 4; t++) begin
            set_coefs(tbl[t].b0, tbl[t].b1, tbl[t].b2, tbl[t].a1, tbl[t].a2);
            rom_len = tbl[t].n;
            exp_y.delete();
            for (int i = 0; i < tbl[t].n; i++) begin
                rom[i] = tbl[t].x[i];
                exp_y.push_back(tbl[t].y[i]);
            end
            apply_reset();
            run1(300);
            check_writes(tbl[t].name, exp_y);
            chk({tbl[t].name, "_sat_flag"}, sat_flag, tbl[t].sat);
            chk({tbl[t].name, "_finish"}, Finish, 1);
        end

        // Identity, 25 samples, timing
        set_coefs(16384, 0, 0, 0, 0);
        rom_len = 25;
        exp_y.delete();
        for (int i = 0; i < 25; i++) begin
            rom[i] = int'($urandom_range(65535)) - 32768;
            exp_y.push_back(rom[i]);
        end
        apply_reset();
        run1(400);
        check_writes("identity", exp_y);
        chk("identity_load_count", ld_cyc.size(), 25);
        if (ld_cyc.size() > 0) chk("identity_first_load", ld_cyc[0], 1);
        for (int i = 1; i < ld_cyc.size(); i++)
            chk($sformatf("identity_load_period[%0d]", i), ld_cyc[i] - ld_cyc[i-1], 7);
        for (int i = 0; i < ld_cyc.size() && i < wr_cyc.size(); i++)
            chk($sformatf("identity_wen_delay[%0d]", i), wr_cyc[i] - ld_cyc[i], 6);
        if (wr_cyc.size() == 25) chk("identity_finish_time", fin_cyc, wr_cyc[24] + 1);
        chk("identity_finish_held", Finish, 1);

        // Randomised coefficients against the reference model
        for (int t = 0; t < 5; t++) begin
            set_coefs(int'($urandom_range(40000)) - 20000, int'($urandom_range(40000)) - 20000,
                      int'($urandom_range(40000)) - 20000, int'($urandom_range(24000)) - 12000,
                      int'($urandom_range(24000)) - 12000);
            rom_len = 10;
            for (int i = 0; i < 10; i++) rom[i] = int'($urandom_range(65535)) - 32768;
            rom[3] = 32767;
            rom[6] = -32768;
            model(10, 1, exp_y, clip);
            apply_reset();
            run1(400);
            check_writes($sformatf("random%0d", t), exp_y);
            chk($sformatf("random%0d_sat_flag", t), sat_flag, clip);
        end

        // Reset during MAC of sample 3, then restart with clean history
        set_coefs(16384, 16384, 0, 0, 0);
        rom_len = 8;
        for (int i = 0; i < 8; i++) rom[i] = int'($urandom_range(20000)) - 10000;
        apply_reset();
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (load) begin
                DIn = 16'(rom[RAddr[5:0]]);
                data_done = 1'b0;
                if (RAddr == 3) found = 1;
            end
        end
        chk("midrst_reached_sample3", found, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_load", load, 0);
        chk("midrst_raddr", RAddr, 0);
        chk("midrst_wen", WEN, 0);
        chk("midrst_yn", Yn, 0);
        chk("midrst_waddr", WAddr, 0);
        chk("midrst_finish", Finish, 0);
        rst = 1'b0;
        model(8, 1, exp_y, clip);
        run1(300);
        if (ld_addr.size() > 0) chk("midrst_restart_addr", ld_addr[0], 0);
        check_writes("midrst", exp_y);

        // Single sample
        set_coefs(16384, 0, 0, 0, 0);
        rom_len = 1;
        rom[0] = -1234;
        exp_y.delete();
        exp_y.push_back(-1234);
        apply_reset();
        run1(100);
        check_writes("single", exp_y);
        chk("single_load_count", ld_cyc.size(), 1);
        chk("single_finish", Finish, 1);

        // Two interleaved channels
        rom2 = '{100, 1000, 200, 2000};
        @(negedge clk);
        rst2 = 1'b0;
        found = 0;
        for (int k = 0; k < 300 && found < 10; k++) begin
            @(negedge clk);
            if (load2) begin
                DIn2 = 16'(rom2[RAddr2[1:0]]);
                data_done2 = (RAddr2 == 3);
            end else begin
                DIn2 = 16'($urandom);
                data_done2 = 1'b0;
            end
            if (WEN2) begin
                w2_addr.push_back(int'(WAddr2));
                w2_data.push_back(int'($signed(Yn2)));
            end
            if (Finish2) found++;
        end
        chk("chan_finish", found, 10);
        chk("chan_write_count", w2_data.size(), 4);
        exp_y = '{100, 1000, 300, 3000};
        for (int i = 0; i < 4 && i < w2_data.size(); i++) begin
            chk($sformatf("chan_waddr[%0d]", i), w2_addr[i], i);
            chk($sformatf("chan_yn[%0d]", i), w2_data[i], exp_y[i]);
        end
        chk("chan_sat_flag", sat_flag2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
